systolic_drain: RTL and testbench

- Output collector at the bottom edge of the weight-stationary MAC array.
- Samples the per-column accumulator results leaving the last MAC row. Column c's results arrive c cycles later than column 0's.
- Deskews the columns so each result vector leaves as one aligned word, buffers the vectors in a FIFO, and hands them downstream on a valid/ready handshake.
- Tracks one burst of N vectors per start pulse and reports busy, done and overflow.

---
 rtl/systolic_pkg.sv | 17 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/systolic_drain.sv | 182 ++++++++++++++++++
 tb/tb_systolic_drain.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic MAC array drain path.
//   MAC_W        : operand width of a single MAC
//   ARRAY_DEPTH  : number of MAC rows (accumulation length)
//   ACC_W        : accumulator width derived from the two above
//   drain_state_t: drain controller states
package systolic_pkg;
    localparam int MAC_W       = 8;
    localparam int ARRAY_DEPTH = 4;
    localparam int ACC_W       = 2 * MAC_W + ARRAY_DEPTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COLLECT,
        FLUSH
    } drain_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous active-high reset.
//   clk, rst            : clock, reset
//   push, push_data     : write request; ignored when full unless popping the same cycle
//   pop                 : read request; ignored when empty
//   pop_data            : head entry, or the last popped entry while empty
//   full, empty, count  : occupancy status
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] last_q;
    logic             wr_en;
    logic             rd_en;

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // While empty, keep presenting the most recently popped word.
    assign pop_data = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/systolic_drain.sv
// Output collector at the bottom edge of the weight-stationary MAC array.
// Deskews the per-column accumulator results, reduces each element to OUT_W,
// buffers aligned vectors and hands them downstream on valid/ready.
// Build option SYSTOLIC_DRAIN_SAT_EN: saturate elements instead of truncating.
//   clk, rst      : clock, synchronous active-high reset
//   start         : one-cycle burst start pulse
//   num_vectors   : burst length N, sampled with start (0 = ignored)
//   acc_in        : bottom-row accumulators, column c at [c*ACC_W +: ACC_W]
//   out_data      : aligned vector, column c at [c*OUT_W +: OUT_W]
//   out_valid     : out_data valid
//   out_ready     : downstream accept
//   busy          : burst in progress
//   done          : one-cycle pulse at burst end
//   overflow      : sticky, an aligned vector was dropped on a full FIFO
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no burst; waiting for start with nonzero N
// WAIT    | pipeline latency until vector 0 is aligned
// COLLECT | push one aligned vector per cycle until N pushed
// FLUSH   | wait for the FIFO to drain, then pulse done
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int ACC_W      = systolic_pkg::ACC_W,
    parameter int OUT_W      = 16,
    parameter int BASE_LAT   = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_vectors,
    input  logic [COLS*ACC_W-1:0]  acc_in,
    output logic [COLS*OUT_W-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);
    // Start edge to the edge of the first push is BASE_LAT+COLS-2 WAIT cycles;
    // the down-counter is loaded one below that so it terminates at zero.
    localparam int WAIT_LOAD = BASE_LAT + COLS - 3;
    localparam int WAIT_W    = $clog2(WAIT_LOAD + 1) + 1;
    localparam int FCNT_W    = $clog2(FIFO_DEPTH) + 1;

    drain_state_t          state;
    drain_state_t          state_nxt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [CNT_W-1:0]      remain;
    logic                  load;
    logic                  push;
    logic                  pop;
    logic                  done_nxt;
    logic                  done_q;
    logic                  overflow_q;
    logic [COLS*OUT_W-1:0] push_data;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FCNT_W-1:0]     fifo_cnt;

    // Column c lags column 0 by c cycles; delaying it by COLS-1-c registers
    // lines every column up with the undelayed last column.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        localparam int D = COLS - 1 - c;
        logic [ACC_W-1:0] col_val;

        if (D == 0) begin : g_nodly
            assign col_val = acc_in[c*ACC_W +: ACC_W];
        end else begin : g_dly
            logic [ACC_W-1:0] dly [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        dly[i] <= '0;
                    end
                end else begin
                    dly[0] <= acc_in[c*ACC_W +: ACC_W];
                    for (int i = 1; i < D; i++) begin
                        dly[i] <= dly[i-1];
                    end
                end
            end
            assign col_val = dly[D-1];
        end

`ifdef SYSTOLIC_DRAIN_SAT_EN
        // Any set bit above OUT_W means the value exceeds the output range.
        assign push_data[c*OUT_W +: OUT_W] =
            (|col_val[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : col_val[OUT_W-1:0];
`else
        logic unused_hi;
        assign unused_hi = ^col_val[ACC_W-1:OUT_W];
        assign push_data[c*OUT_W +: OUT_W] = col_val[OUT_W-1:0];
`endif
    end

    sync_fifo #(
        .WIDTH (COLS * OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign overflow  = overflow_q;

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        push      = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (num_vectors != '0)) begin
                    load      = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = COLLECT;
                end
            end
            COLLECT: begin
                push = 1'b1;
                if (remain == CNT_W'(1)) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if ((fifo_cnt == '0) || ((fifo_cnt == FCNT_W'(1)) && pop)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            remain     <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            // A dropped vector still counts toward the burst length.
            if (push && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
            if (load) begin
                wait_cnt <= WAIT_W'(WAIT_LOAD);
                remain   <= num_vectors;
            end else begin
                if ((state == WAIT) && (wait_cnt != '0)) begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
                if (push) begin
                    remain <= remain - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain against a queue-based reference
// model. Every step drives inputs on the falling edge, advances the model
// over the rising edge and compares all outputs shortly after it.
module tb_systolic_drain;
    localparam int COLS  = 4;
    localparam int ACC_W = 19;
    localparam int OUT_W = 16;
    localparam int BL    = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXN  = 16;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  start = 1'b0;
    logic [CNT_W-1:0]      num_vectors = '0;
    logic [COLS*ACC_W-1:0] acc_in = '0;
    logic [COLS*OUT_W-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  busy;
    logic                  done;
    logic                  overflow;

    always #5 clk = ~clk;

    systolic_drain #(
        .COLS(COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .BASE_LAT(BL),
        .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .acc_in(acc_in), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .overflow(overflow)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model state
    logic [COLS*OUT_W-1:0] q[$];
    logic [COLS*OUT_W-1:0] last_m = '0;
    logic [ACC_W-1:0]      val [MAXN][COLS];
    int  t_m = 0;
    int  n_m = 0;
    int  pushes = 0;
    bit  busy_m = 0;
    bit  done_m = 0;
    bit  ovf_m = 0;

    // handshake observation
    int                    pop_cnt = 0;
    logic [COLS*OUT_W-1:0] last_seen = '0;

    function automatic logic [OUT_W-1:0] red(input logic [ACC_W-1:0] x);
`ifdef SYSTOLIC_DRAIN_SAT_EN
        if (int'(x) > (1 << OUT_W) - 1) return {OUT_W{1'b1}};
        return x[OUT_W-1:0];
`else
        return x[OUT_W-1:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @edge %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit s, input int n, input bit rdy);
        logic [COLS*OUT_W-1:0] vec;
        logic [COLS*OUT_W-1:0] exp_data;
        bit pop;
        int v;
        @(negedge clk);
        rst = r;
        start = s;
        num_vectors = CNT_W'(n);
        out_ready = rdy;
        // column c of vector v appears on acc_in at edge T+BL+v+c
        for (int c = 0; c < COLS; c++) begin
            v = cyc - t_m - BL - c;
            if (v >= 0 && v < n_m) acc_in[c*ACC_W +: ACC_W] = val[v][c];
            else                   acc_in[c*ACC_W +: ACC_W] = ACC_W'($urandom);
        end
        #1;
        if (!r && out_valid && out_ready) begin
            pop_cnt++;
            last_seen = out_data;
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            last_m = '0;
            busy_m = 0; done_m = 0; ovf_m = 0;
            n_m = 0; pushes = 0;
        end else begin
            pop = (q.size() > 0) && rdy;
            done_m = 0;
            if (busy_m) begin
                if (pushes < n_m && cyc == t_m + BL + COLS - 1 + pushes) begin
                    for (int c = 0; c < COLS; c++) vec[c*OUT_W +: OUT_W] = red(val[pushes][c]);
                    pushes++;
                    if (pop) begin
                        last_m = q.pop_front();
                        pop = 0;
                    end
                    if (q.size() < DEPTH) q.push_back(vec);
                    else ovf_m = 1;
                end else if (pushes == n_m && (q.size() - (pop ? 1 : 0)) == 0) begin
                    done_m = 1;
                    busy_m = 0;
                end
            end else if (s && n != 0) begin
                busy_m = 1;
                t_m = cyc;
                n_m = n;
                pushes = 0;
            end
            if (pop) last_m = q.pop_front();
        end
        #1;
        if (q.size() > 0) exp_data = q[0];
        else              exp_data = last_m;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("out_data",  out_data, exp_data);
        chk("busy",      64'(busy), 64'(busy_m));
        chk("done",      64'(done), 64'(done_m));
        chk("overflow",  64'(overflow), 64'(ovf_m));
        cyc++;
    endtask

    function automatic bit rnd_rdy(input int mode);
        if (mode == 2) return bit'($urandom_range(0, 1));
        return bit'(mode);
    endfunction

    task automatic run(input int k, input int mode);
        for (int i = 0; i < k; i++) step(0, 0, 0, rnd_rdy(mode));
    endtask

    task automatic finish_burst(input int mode);
        int k = 0;
        while (busy_m && k < 200) begin
            step(0, 0, 0, rnd_rdy(mode));
            k++;
        end
        step(0, 0, 0, rnd_rdy(mode));
    endtask

    task automatic rand_vals();
        for (int v = 0; v < MAXN; v++)
            for (int c = 0; c < COLS; c++)
                val[v][c] = $urandom_range(0, 1) ? ACC_W'($urandom) : ACC_W'($urandom_range(0, 65535));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset, then idle with toggling acc_in
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        run(6, 1);

        // N=3, values 100*v+c, always ready
        for (int v = 0; v < MAXN; v++)
            for (int c = 0; c < COLS; c++) val[v][c] = ACC_W'(100 * v + c);
        pop_cnt = 0;
        step(0, 1, 3, 1);
        finish_burst(1);
        chk("n3_pops", 64'(pop_cnt), 64'd3);
        chk("n3_last", last_seen, {16'd203, 16'd202, 16'd201, 16'd200});

        // start with N=0 is ignored
        step(0, 1, 0, 1);
        chk("n0_busy", 64'(busy), 64'd0);
        run(3, 1);

        // N=6 with ready low: four buffered, two dropped
        rand_vals();
        pop_cnt = 0;
        step(0, 1, 6, 0);
        run(16, 0);
        chk("n6_ovf", 64'(overflow), 64'd1);
        finish_burst(1);
        chk("n6_pops", 64'(pop_cnt), 64'd4);
        step(1, 0, 0, 0);

        // width reduction of 0x4_0001
        rand_vals();
        val[0][0] = 19'h40001;
        pop_cnt = 0;
        step(0, 1, 1, 1);
        finish_burst(1);
        chk("n1_pops", 64'(pop_cnt), 64'd1);
`ifdef SYSTOLIC_DRAIN_SAT_EN
        chk("reduce_elem0", 64'(last_seen[OUT_W-1:0]), 64'h0000_FFFF);
`else
        chk("reduce_elem0", 64'(last_seen[OUT_W-1:0]), 64'h0000_0001);
`endif

        // further starts during a burst are ignored
        rand_vals();
        pop_cnt = 0;
        step(0, 1, 2, 1);
        run(3, 1);
        step(0, 1, 5, 1);
        run(5, 1);
        step(0, 1, 7, 1);
        finish_burst(1);
        chk("restart_pops", 64'(pop_cnt), 64'd2);

        // reset in the middle of COLLECT, then a fresh burst
        rand_vals();
        step(0, 1, 4, 0);
        run(9, 0);
        step(1, 0, 0, 0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rand_vals();
        step(0, 1, 3, 1);
        finish_burst(2);

        // random bursts with random back-pressure
        for (int b = 0; b < 6; b++) begin
            rand_vals();
            n = $urandom_range(1, 10);
            step(0, 1, n, rnd_rdy(2));
            finish_burst(2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
